dma_write_engine: RTL and testbench
===================================

Name: dma_write_engine

Overview:
Upstream feeder for the memory subsystem. It accepts a transfer descriptor (destination base, word count) and a valid/ready input stream. Words are buffered in a small FIFO and issued as single-word writes on the memory subsystem's addr/data_in/write_enable bus, one per cycle. The block is the data-moving engine behind the DMA control register and fills the weight/data banks from the host or loader stream.

Parameters:
DATA_WIDTH, 32, stream and memory word width
ADDR_WIDTH, 16, memory address width
LEN_WIDTH, 16, transfer length field width (words)
FIFO_DEPTH, 4, input buffer entries (power of 2, >=2)
CTRL_BASE, 16'hFF00, start of the reserved control-register region; writes are never issued at or above this address

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
start  in  1  descriptor strobe, sampled only in IDLE
dst_base  in  ADDR_WIDTH  first destination word address
xfer_len  in  LEN_WIDTH  number of words to write
abort  in  1  cancel the current transfer
busy  out  1  high in BUSY
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on a rejected descriptor
s_valid  in  1  stream word valid
s_data  in  DATA_WIDTH  stream word
s_ready  out  1  stream ready
mem_addr  out  ADDR_WIDTH  write address to memory subsystem
mem_data  out  DATA_WIDTH  write data to memory subsystem
mem_we  out  1  write strobe to memory subsystem
mem_stall  in  1  arbitration backpressure; write not taken while high

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, all counters 0. busy, done, err, s_ready, mem_we = 0. mem_addr and mem_data = 0.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 with xfer_len==0, or dst_base+xfer_len-1 >= CTRL_BASE (computed at ADDR_WIDTH+1 bits, overflow counts as a violation): err=1 for the next cycle, stay in IDLE.
- IDLE, start=1 with a valid descriptor: latch base and len, clear acc_cnt and wr_cnt, go to BUSY next cycle.
- start while in BUSY or DONE is ignored. abort in IDLE is ignored.
- s_ready = BUSY && FIFO not full && acc_cnt < len, registered-free (combinational from state and counters). A beat is accepted when s_valid && s_ready; it is pushed to the FIFO and acc_cnt is incremented. Words beyond len are never accepted.
- Write stage: the output register holds one pending write. A write completes in any cycle with mem_we=1 && mem_stall=0. When the register is empty or completing, and the FIFO is non-empty, it pops the head and loads mem_data=head, mem_addr=base+wr_cnt, mem_we=1, then increments wr_cnt. While mem_stall=1, mem_addr, mem_data and mem_we are held stable.
- Latency: a beat accepted in cycle N drives mem_we=1 in cycle N+2 at the earliest. Sustained throughput is 1 word/cycle with no stall.
- FIFO is full when FIFO_DEPTH entries are held; simultaneous push and pop when full is not permitted, because s_ready is already 0.
- Completion: when the write of word len-1 completes, go to DONE. DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
- abort in BUSY: next cycle state=IDLE, FIFO flushed, mem_we=0, no done and no err. A write presented in the abort cycle with mem_stall=0 is still counted as taken.
- Addresses are strictly increasing; wrap cannot occur because of the CTRL_BASE check.
- busy=1 exactly while state==BUSY.

Test Plan:
- Basic: dst_base=0x0100, len=4, stream 0xA0..0xA3 back-to-back, mem_stall=0 -> writes at 0x0100..0x0103 with matching data on consecutive cycles, first mem_we 2 cycles after the first beat, done pulse 1 cycle after the last write, busy low afterward.
- Backpressure: len=8, mem_stall held high for 6 cycles mid-transfer -> mem bus held stable, s_ready drops after 4 buffered words plus 1 pending, no loss or duplication, all 8 writes correct and in order.
- Rejects: start with len=0 -> err pulse, busy stays 0. start with dst_base=0xFEFE, len=3 (last address 0xFF00) -> err, no mem_we. dst_base=0xFEFD, len=3 -> accepted.
- Over-supply and restart: len=2, s_valid held high with 5 words -> only 2 accepted, s_ready=0 afterward. start pulsed during BUSY is ignored.
- Abort: len=16, abort after 5 writes -> idle next cycle, FIFO empty, no done. New descriptor dst_base=0x0200, len=1 completes normally.
- Reset mid-transfer: reset=0 asynchronously during BUSY with mem_we=1 -> mem_we, busy and s_ready drop immediately. After release, state is IDLE and the next transfer behaves as from power-up.

Source files
------------

// File: rtl/dma_write_engine.sv
// dma_write_engine: descriptor-driven stream-to-memory write engine.
// Accepts a (dst_base, xfer_len) descriptor and a valid/ready word stream.
// Words are buffered in a small FIFO and issued as single-word writes, one
// per cycle, on the memory subsystem's mem_addr/mem_data/mem_we bus.
//
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   start          descriptor strobe, sampled in IDLE only
//   dst_base       first destination word address
//   xfer_len       number of words to transfer
//   abort          cancel the transfer in progress
//   busy           high while a transfer is in progress
//   done           one-cycle pulse after the last write completes
//   err            one-cycle pulse after a rejected descriptor
//   s_valid/s_data/s_ready   input word stream (s_ready is combinational)
//   mem_addr/mem_data/mem_we registered write request
//   mem_stall      write not taken while high; request is held stable
module dma_write_engine #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           LEN_WIDTH  = 16,
   parameter int unsigned           FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] CTRL_BASE  = 16'hFF00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   input  logic [LEN_WIDTH-1:0]  xfer_len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic                  mem_stall
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   // Wide enough that base+len-1 can never wrap, so overflow shows up as >= CTRL_BASE.
   localparam int unsigned CHK_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  err_nxt;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  acc_cnt;
   logic [LEN_WIDTH-1:0]  wr_cnt;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;

   logic [CHK_W-1:0]      desc_end;
   logic                  desc_ok;
   logic                  desc_accept;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  taken;
   logic                  load;
   logic                  last_taken;
   logic                  abort_busy;

   // Descriptor check: non-zero length and last address below the control region.
   assign desc_end    = CHK_W'(dst_base) + CHK_W'(xfer_len) - CHK_W'(1);
   assign desc_ok     = (xfer_len != '0) && (desc_end < CHK_W'(CTRL_BASE));
   assign desc_accept = (state == ST_IDLE) && start && desc_ok;

   // FIFO status: pointers carry one extra wrap bit to tell full from empty.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign abort_busy = (state == ST_BUSY) && abort;

   // Stream handshake; never accepts beyond the descriptor length.
   assign s_ready = (state == ST_BUSY) && !fifo_full && (acc_cnt < len_q);
   assign push    = s_valid && s_ready;

   // Output register reloads when empty or when its write is taken this cycle.
   assign taken      = mem_we && !mem_stall;
   assign load       = (state == ST_BUSY) && !abort && !fifo_empty && (!mem_we || taken);
   // wr_cnt already counts the pending word, so wr_cnt == len means it is the last one.
   assign last_taken = taken && (wr_cnt == len_q);

   assign busy = (state == ST_BUSY);
   assign done = (state == ST_DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= err_nxt;
      end
   end

   // Next-state and error-pulse logic.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (desc_ok) state_nxt = ST_BUSY;
               else         err_nxt   = 1'b1;
            end
         end
         ST_BUSY: begin
            if (abort)           state_nxt = ST_IDLE;
            else if (last_taken) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Descriptor latch and beat/write counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q  <= '0;
         len_q   <= '0;
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else if (desc_accept) begin
         base_q  <= dst_base;
         len_q   <= xfer_len;
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else begin
         if (push) acc_cnt <= acc_cnt + LEN_WIDTH'(1);
         if (load) wr_cnt  <= wr_cnt + LEN_WIDTH'(1);
      end
   end

   // FIFO pointers; abort flushes the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (abort_busy) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (load) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // FIFO storage holds data only; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= s_data;
   end

   // Write request register; held stable while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (abort_busy) begin
         mem_we   <= 1'b0;
      end else if (load) begin
         mem_we   <= 1'b1;
         mem_addr <= base_q + ADDR_WIDTH'(wr_cnt);
         mem_data <= fifo_mem[rd_ptr[PTR_W-1:0]];
      end else if (taken) begin
         mem_we   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: directed and randomized transfers checked
// against an order-based reference (word i of the stream lands at base+i).
module tb_dma_write_engine;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned LW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] dst_base;
   logic [LW-1:0] xfer_len;
   logic          abort;
   logic          busy;
   logic          done;
   logic          err;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_we;
   logic          mem_stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dma_write_engine dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dst_base  (dst_base),
      .xfer_len  (xfer_len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .mem_stall (mem_stall)
   );

   logic [DW-1:0] words   [$];
   logic [AW-1:0] wr_addr [$];
   logic [DW-1:0] wr_data [$];
   int            wr_cyc  [$];
   int            acc_n;
   int            first_acc;
   int            done_cyc;
   int            timeout;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] b, input logic [LW-1:0] l);
      start    = 1'b1;
      dst_base = b;
      xfer_len = l;
      next_cycle();
      start    = 1'b0;
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // Drives the stream and records every taken write until done, abort or cycle budget.
   task automatic run(input int len, input int stall_at, input int stall_n, input int abort_at,
                      input bit gaps, input bit poke, input bit fill_chk, input int max_cyc);
      int            idx;
      int            cyc;
      bit            acc;
      bit            prev_stall;
      bit            prev_we;
      bit            stop;
      logic [AW-1:0] prev_a;
      logic [DW-1:0] prev_d;
      idx = 0; cyc = 0; prev_stall = 0; prev_we = 0; stop = 0;
      prev_a = '0; prev_d = '0;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      acc_n = 0; first_acc = -1; done_cyc = -1; timeout = 0;
      while (!stop) begin
         if (cyc >= max_cyc) begin
            timeout = 1;
            break;
         end
         s_valid   = (idx < words.size()) && (!gaps || ($urandom_range(3) != 0));
         s_data    = (idx < words.size()) ? words[idx] : '0;
         mem_stall = (cyc >= stall_at) && (cyc < stall_at + stall_n);
         abort     = (abort_at >= 0) && (wr_addr.size() >= abort_at);
         start     = poke && (cyc == 1);
         if (start) begin
            dst_base = 16'h0300;
            xfer_len = 16'd7;
         end
         @(negedge clk);
         if (cyc == 0) chk("busy_first_cycle", 64'(busy), 64'(1));
         if (acc_n >= len) chk("s_ready_after_len", 64'(s_ready), 64'(0));
         chk("occupancy_le_5", 64'((acc_n - wr_addr.size()) <= 5), 64'(1));
         if (fill_chk && cyc == stall_at + stall_n - 1) begin
            chk("stall_s_ready_low", 64'(s_ready), 64'(0));
            chk("stall_buffered_5", 64'(acc_n - wr_addr.size()), 64'(5));
         end
         if (mem_stall && prev_stall && prev_we) begin
            chk("stall_we_held", 64'(mem_we), 64'(1));
            chk("stall_addr_held", 64'(mem_addr), 64'(prev_a));
            chk("stall_data_held", 64'(mem_data), 64'(prev_d));
         end
         acc = s_valid && s_ready;
         if (acc) begin
            acc_n++;
            if (first_acc < 0) first_acc = cyc;
         end
         if (mem_we && !mem_stall) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
            wr_cyc.push_back(cyc);
         end
         if (done) done_cyc = cyc;
         prev_stall = mem_stall;
         prev_we    = mem_we;
         prev_a     = mem_addr;
         prev_d     = mem_data;
         stop       = abort || (done_cyc >= 0);
         next_cycle();
         if (acc) idx++;
         cyc++;
      end
      s_valid = 1'b0; mem_stall = 1'b0; abort = 1'b0; start = 1'b0;
   endtask

   // Reference: the i-th write goes to base+i and carries the i-th stream word.
   task automatic check_writes(input string tag, input logic [AW-1:0] base, input int exp_n,
                               input bit chk_count);
      logic [AW-1:0] ea;
      chk($sformatf("%s_timeout", tag), 64'(timeout), 64'(0));
      if (chk_count) chk($sformatf("%s_count", tag), 64'(wr_addr.size()), 64'(exp_n));
      for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
         ea = base + AW'(i);
         chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(ea));
         chk($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(words[i]));
      end
   endtask

   task automatic check_done(input string tag);
      int exp_c;
      exp_c = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] + 1 : -2;
      chk($sformatf("%s_done_cycle", tag), 64'(done_cyc), 64'(exp_c));
   endtask

   task automatic idle_checks(input string tag);
      @(negedge clk);
      chk($sformatf("%s_busy0", tag), 64'(busy), 64'(0));
      chk($sformatf("%s_done0", tag), 64'(done), 64'(0));
      chk($sformatf("%s_we0", tag), 64'(mem_we), 64'(0));
      chk($sformatf("%s_ready0", tag), 64'(s_ready), 64'(0));
      next_cycle();
   endtask

   task automatic reject(input string tag, input logic [AW-1:0] b, input logic [LW-1:0] l);
      issue(b, l);
      @(negedge clk);
      chk($sformatf("%s_err1", tag), 64'(err), 64'(1));
      chk($sformatf("%s_busy0", tag), 64'(busy), 64'(0));
      next_cycle();
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("%s_err0_%0d", tag, k), 64'(err), 64'(0));
         chk($sformatf("%s_no_we_%0d", tag, k), 64'(mem_we), 64'(0));
         chk($sformatf("%s_no_ready_%0d", tag, k), 64'(s_ready), 64'(0));
         next_cycle();
      end
      s_valid = 1'b0;
   endtask

   task automatic random_xfer(input string tag);
      int            l;
      logic [AW-1:0] b;
      l = $urandom_range(10, 1);
      b = AW'($urandom_range(32'hFF00 - l));
      fill_words(l);
      issue(b, LW'(l));
      run(l, $urandom_range(8), $urandom_range(4), -1, 1'b1, 1'b0, 1'b0, 300);
      check_writes(tag, b, l, 1'b1);
      check_done(tag);
      idle_checks(tag);
   endtask

   initial begin
      bit found;
      reset = 1'b0; start = 1'b0; dst_base = '0; xfer_len = '0; abort = 1'b0;
      s_valid = 1'b0; s_data = '0; mem_stall = 1'b0;

      // Power-up reset state.
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_s_ready", 64'(s_ready), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_data", 64'(mem_data), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      next_cycle();

      // Basic back-to-back transfer with latency and completion timing.
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(32'hA0 + 32'(i));
      issue(16'h0100, 16'd4);
      run(4, 1000, 0, -1, 1'b0, 1'b0, 1'b0, 40);
      check_writes("basic", 16'h0100, 4, 1'b1);
      chk("basic_first_acc", 64'(first_acc), 64'(0));
      chk("basic_latency", 64'((wr_cyc.size() > 0) ? wr_cyc[0] - first_acc : -1), 64'(2));
      chk("basic_consecutive", 64'((wr_cyc.size() == 4) ? wr_cyc[3] - wr_cyc[0] : -1), 64'(3));
      check_done("basic");
      idle_checks("basic_after");

      // Backpressure: six stalled cycles mid-transfer.
      fill_words(8);
      issue(16'h1230, 16'd8);
      run(8, 3, 6, -1, 1'b0, 1'b0, 1'b1, 80);
      check_writes("bp", 16'h1230, 8, 1'b1);
      check_done("bp");
      idle_checks("bp_after");

      // Rejected descriptors and the highest legal one.
      reject("rej_len0", 16'h0010, 16'd0);
      reject("rej_ctrl", 16'hFEFE, 16'd3);
      reject("rej_wrap", 16'hFFF0, 16'h0020);
      fill_words(3);
      issue(16'hFEFD, 16'd3);
      run(3, 1000, 0, -1, 1'b0, 1'b0, 1'b0, 40);
      check_writes("edge_ok", 16'hFEFD, 3, 1'b1);
      check_done("edge_ok");
      idle_checks("edge_after");

      // Over-supply with start poked during BUSY.
      fill_words(5);
      issue(16'h0040, 16'd2);
      run(2, 1000, 0, -1, 1'b0, 1'b1, 1'b0, 40);
      chk("over_accepted", 64'(acc_n), 64'(2));
      check_writes("over", 16'h0040, 2, 1'b1);
      check_done("over");
      idle_checks("over_after");

      // Abort after five writes, then a fresh single-word transfer.
      fill_words(16);
      issue(16'h1000, 16'd16);
      run(16, 1000, 0, 5, 1'b0, 1'b0, 1'b0, 60);
      @(negedge clk);
      chk("abort_busy0", 64'(busy), 64'(0));
      chk("abort_we0", 64'(mem_we), 64'(0));
      chk("abort_ready0", 64'(s_ready), 64'(0));
      chk("abort_no_done", 64'(done_cyc), 64'(-1));
      chk("abort_count_range", 64'(wr_addr.size() >= 5 && wr_addr.size() <= 6), 64'(1));
      check_writes("abort", 16'h1000, wr_addr.size(), 1'b0);
      next_cycle();
      idle_checks("abort_idle");
      fill_words(1);
      issue(16'h0200, 16'd1);
      run(1, 1000, 0, -1, 1'b0, 1'b0, 1'b0, 40);
      check_writes("post_abort", 16'h0200, 1, 1'b1);
      check_done("post_abort");
      idle_checks("post_abort_after");

      // Asynchronous reset while a write is on the bus.
      fill_words(8);
      issue(16'h0400, 16'd8);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         s_valid = 1'b1;
         s_data  = words[k % 8];
         @(negedge clk);
         if (mem_we === 1'b1) found = 1'b1;
         else next_cycle();
      end
      chk("rst_mid_we_seen", 64'(found), 64'(1));
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_we", 64'(mem_we), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_ready", 64'(s_ready), 64'(0));
      chk("rst_mid_addr", 64'(mem_addr), 64'(0));
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      next_cycle();
      idle_checks("rst_release");
      random_xfer("post_rst");

      // Randomized transfers with gaps and stalls.
      for (int t = 0; t < 6; t++) random_xfer($sformatf("rnd%0d", t));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
